// File: rtl/adding_pkg.sv
// Shared types and constants for the adding-machine control unit.
// Opcodes are IR[7:6]; the control word bundles every datapath strobe.
package adding_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic [3:0] {
    StRst,
    StIdle,
    StFetch,
    StDecode,
    StLda,
    StSta,
    StAdd,
    StJmp,
    StErr
  } ctrl_state_t;

  typedef struct packed {
    logic load_ir;
    logic load_acc;
    logic sel_alu;
    logic sel_bus;
    logic pass_add;
    logic ld_pc;
    logic clr_pc;
    logic inc_pc;
    logic ir_on_adr;
    logic pc_on_adr;
    logic rd_mem;
    logic wr_mem;
    logic acc_on_dbus;
    logic instr_done;
    logic bus_error;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

  // States that hold a memory request open and may wait on mem_ready.
  function automatic logic is_mem_state(ctrl_state_t s);
    return (s == StFetch) || (s == StLda) || (s == StSta);
  endfunction

endpackage

// File: rtl/adding_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master:
// it receives opcode, ready and run, and drives every strobe.
interface adding_controller_if;
  logic [1:0] ir_opcode;
  logic       mem_ready;
  logic       run;
  logic       load_IR;
  logic       load_acc;
  logic       sel_alu;
  logic       sel_bus;
  logic       pass_add;
  logic       ld_pc;
  logic       clr_pc;
  logic       inc_pc;
  logic       ir_on_adr;
  logic       pc_on_adr;
  logic       rd_mem;
  logic       wr_mem;
  logic       acc_on_dbus;
  logic       instr_done;
  logic       bus_error;

  modport master (
    input  ir_opcode, mem_ready, run,
    output load_IR, load_acc, sel_alu, sel_bus, pass_add, ld_pc, clr_pc, inc_pc,
           ir_on_adr, pc_on_adr, rd_mem, wr_mem, acc_on_dbus, instr_done, bus_error
  );

  modport slave (
    output ir_opcode, mem_ready, run,
    input  load_IR, load_acc, sel_alu, sel_bus, pass_add, ld_pc, clr_pc, inc_pc,
           ir_on_adr, pc_on_adr, rd_mem, wr_mem, acc_on_dbus, instr_done, bus_error
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter for a pending memory request; flags when the request has
// waited TIMEOUT-1 cycles so the controller can trap on this cycle's no-ready.
module mem_wait_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adding_controller.sv
// Fetch/decode/execute sequencer for the 4-instruction adding machine.
// Strobes are decoded from state and mem_ready; reset forces them all low.
module adding_controller
  import adding_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 clock,
  input logic                 reset,
  adding_controller_if.master bus
);

  ctrl_state_t state_q, state_d;
  ctrl_word_t  ctrl;
  logic        timeout;
  logic        tmr_clr;
  logic        tmr_en;

  // Any state change counts as a fresh entry, so the wait count restarts.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = is_mem_state(state_q) && !bus.mem_ready;

  mem_wait_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    unique case (state_q)
      StRst: begin
        ctrl.clr_pc = 1'b1;
        state_d     = StIdle;
      end
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        ctrl.pc_on_adr = 1'b1;
        ctrl.rd_mem    = 1'b1;
        if (bus.mem_ready) begin
          ctrl.load_ir = 1'b1;
          ctrl.inc_pc  = 1'b1;
          state_d      = StDecode;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StDecode: begin
        unique case (bus.ir_opcode)
          OP_LDA:  state_d = StLda;
          OP_STA:  state_d = StSta;
          OP_ADD:  state_d = StAdd;
          default: state_d = StJmp;
        endcase
      end
      StLda: begin
        ctrl.ir_on_adr = 1'b1;
        ctrl.rd_mem    = 1'b1;
        if (bus.mem_ready) begin
          ctrl.sel_bus    = 1'b1;
          ctrl.load_acc   = 1'b1;
          ctrl.instr_done = 1'b1;
          state_d         = bus.run ? StFetch : StIdle;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StSta: begin
        ctrl.ir_on_adr   = 1'b1;
        ctrl.wr_mem      = 1'b1;
        ctrl.acc_on_dbus = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = bus.run ? StFetch : StIdle;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StAdd: begin
        ctrl.sel_alu    = 1'b1;
        ctrl.pass_add   = 1'b1;
        ctrl.load_acc   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = bus.run ? StFetch : StIdle;
      end
      StJmp: begin
        ctrl.ld_pc      = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = bus.run ? StFetch : StIdle;
      end
      StErr: begin
        ctrl.bus_error = 1'b1;
      end
      default: begin
        state_d = StErr;
      end
    endcase
    // No partial IR/acc load or stray request while reset is held.
    if (reset) ctrl = CTRL_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.load_IR     = ctrl.load_ir;
  assign bus.load_acc    = ctrl.load_acc;
  assign bus.sel_alu     = ctrl.sel_alu;
  assign bus.sel_bus     = ctrl.sel_bus;
  assign bus.pass_add    = ctrl.pass_add;
  assign bus.ld_pc       = ctrl.ld_pc;
  assign bus.clr_pc      = ctrl.clr_pc;
  assign bus.inc_pc      = ctrl.inc_pc;
  assign bus.ir_on_adr   = ctrl.ir_on_adr;
  assign bus.pc_on_adr   = ctrl.pc_on_adr;
  assign bus.rd_mem      = ctrl.rd_mem;
  assign bus.wr_mem      = ctrl.wr_mem;
  assign bus.acc_on_dbus = ctrl.acc_on_dbus;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.bus_error   = ctrl.bus_error;

endmodule
